// File: rtl/lfsr_gen.sv
// ============================================================================
// Module   : lfsr_gen
// Brief    : Parametrised Galois LFSR pseudo-random word source with a
//            valid/ready output stream, runtime seed reload, zero-seed
//            substitution and hardware period measurement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h0040_0006,
    parameter logic [WIDTH-1:0] SEED  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             period_wrap,
    output logic [WIDTH-1:0] period_len,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    // A zero seed would lock the register at zero forever, so it is replaced.
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? ALL_ONES : SEED;
    // x^0 is always present through the shift-in of the feedback bit, so
    // bit 0 of the mask never contributes an XOR.
    localparam logic [WIDTH-1:0] TAP_MASK  = {TAPS[WIDTH-1:1], 1'b0};

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_value;
    logic             feedback;
    logic             seed_zero;
    logic             adv;

    // Galois step: shift left, feedback enters bit 0 and toggles tapped bits.
    always_comb begin
        feedback   = state[WIDTH-1];
        next_state = {state[WIDTH-2:0], feedback} ^ (TAP_MASK & {WIDTH{feedback}});
    end

    // Seed reload value with zero-seed substitution.
    always_comb begin
        seed_zero  = (seed_in == '0);
        load_value = seed_zero ? ALL_ONES : seed_in;
    end

    // Advance when enabled, not reloading, and the output slot is free or
    // being consumed this cycle.
    assign adv = en & ~seed_load & (~out_valid | out_ready);

    // Generator state, output stream, and period measurement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEED_INIT;
            seed_reg    <= SEED_INIT;
            cnt         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            period_wrap <= 1'b0;
            period_len  <= '0;
            seed_err    <= 1'b0;
        end else begin
            period_wrap <= 1'b0;
            seed_err    <= 1'b0;
            if (seed_load) begin
                // Reload wins over any handshake; the pending word is dropped.
                state     <= load_value;
                seed_reg  <= load_value;
                seed_err  <= seed_zero;
                out_valid <= 1'b0;
                cnt       <= '0;
            end else if (adv) begin
                out_data  <= state;
                out_valid <= 1'b1;
                state     <= next_state;
                if (next_state == seed_reg) begin
                    // The word now leaving is the last one of the period.
                    period_len  <= cnt + ONE;
                    cnt         <= '0;
                    period_wrap <= 1'b1;
                end else begin
                    cnt <= cnt + ONE;
                end
            end else if (out_valid && out_ready) begin
                // Consumed with no replacement available (en low).
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================================
// Module   : tb_lfsr_gen
// Brief    : Self-checking bench for lfsr_gen (32/4/10-bit configurations)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 32-bit default instance
    logic        en_a = 1'b0, sl_a = 1'b0, rdy_a = 1'b0;
    logic [31:0] si_a = '0;
    logic [31:0] out_data_a, len_a;
    logic        out_valid_a, wrap_a, err_a;

    // 4-bit instance
    logic        en_b = 1'b0, sl_b = 1'b0, rdy_b = 1'b0;
    logic [3:0]  si_b = '0;
    logic [3:0]  out_data_b, len_b;
    logic        out_valid_b, wrap_b, err_b;

    // 10-bit instance
    logic        en_c = 1'b0, sl_c = 1'b0, rdy_c = 1'b0;
    logic [9:0]  si_c = '0;
    logic [9:0]  out_data_c, len_c;
    logic        out_valid_c, wrap_c, err_c;

    lfsr_gen u_a (
        .clk(clk), .rst(rst), .en(en_a), .seed_load(sl_a), .seed_in(si_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(rdy_a),
        .period_wrap(wrap_a), .period_len(len_a), .seed_err(err_a)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'h2), .SEED(4'hF)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .seed_load(sl_b), .seed_in(si_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(rdy_b),
        .period_wrap(wrap_b), .period_len(len_b), .seed_err(err_b)
    );

    lfsr_gen #(.WIDTH(10), .TAPS(10'h008), .SEED(10'h3FF)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .seed_load(sl_c), .seed_in(si_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(rdy_c),
        .period_wrap(wrap_c), .period_len(len_c), .seed_err(err_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];

    // Model of instance A
    logic [63:0] ma_state, ma_seed, ma_last;
    logic        ma_valid, ma_err;
    // Model of instance B
    logic [63:0] mb_state, mb_seed, mb_cnt, mb_len;

    // Reference Galois step written bit by bit from the polynomial definition
    function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] t, input int w);
        logic [63:0] n;
        logic        fb;
        fb   = s[w-1];
        n    = '0;
        n[0] = fb;
        for (int i = 1; i < w; i++) n[i] = s[i-1] ^ (t[i] & fb);
        return n;
    endfunction

    task automatic reset_model_a();
        ma_state = 64'hFFFF_FFFF;
        ma_seed  = 64'hFFFF_FFFF;
        ma_last  = '0;
        ma_valid = 1'b0;
        ma_err   = 1'b0;
        qa.delete();
    endtask

    // One clock of instance A: drive, update model, push expectation, check
    task automatic cycle_a(input logic e, input logic sl, input logic [31:0] si, input logic rdy);
        logic        adv;
        logic [63:0] exp;
        en_a = e; sl_a = sl; si_a = si; rdy_a = rdy;
        adv    = e && !sl && (!ma_valid || rdy);
        ma_err = 1'b0;
        if (sl) begin
            ma_state = (si == 32'h0) ? 64'hFFFF_FFFF : {32'h0, si};
            ma_seed  = ma_state;
            ma_valid = 1'b0;
            ma_err   = (si == 32'h0);
        end else if (adv) begin
            qa.push_back(ma_state);
            ma_last  = ma_state;
            ma_state = lfsr_step(ma_state, 64'h0040_0006, 32);
            ma_valid = 1'b1;
        end else if (ma_valid && rdy) begin
            ma_valid = 1'b0;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid_a !== ma_valid) begin
            n_bad++; $display("FAIL a_valid: got %b expected %b", out_valid_a, ma_valid);
        end
        n_cmp++;
        if (err_a !== ma_err) begin
            n_bad++; $display("FAIL a_seed_err: got %b expected %b", err_a, ma_err);
        end
        n_cmp++;
        if (wrap_a !== 1'b0) begin
            n_bad++; $display("FAIL a_wrap: got %b expected 0", wrap_a);
        end
        if (adv) begin
            exp = qa.pop_front();
            n_cmp++;
            if (out_data_a !== exp[31:0]) begin
                n_bad++; $display("FAIL a_data: got %h expected %h", out_data_a, exp[31:0]);
            end
        end else if (ma_valid) begin
            n_cmp++;
            if (out_data_a !== ma_last[31:0]) begin
                n_bad++; $display("FAIL a_hold: got %h expected %h", out_data_a, ma_last[31:0]);
            end
        end
    endtask

    // One clock of instance B (always enabled, always ready)
    task automatic cycle_b(input logic sl, input logic [3:0] si);
        logic        wrap;
        logic [63:0] nxt, exp;
        en_b = 1'b1; rdy_b = 1'b1; sl_b = sl; si_b = si;
        wrap = 1'b0;
        if (sl) begin
            mb_state = (si == 4'h0) ? 64'hF : {60'h0, si};
            mb_seed  = mb_state;
            mb_cnt   = '0;
        end else begin
            qb.push_back(mb_state);
            nxt = lfsr_step(mb_state, 64'h2, 4);
            if (nxt == mb_seed) begin
                wrap   = 1'b1;
                mb_len = mb_cnt + 64'd1;
                mb_cnt = '0;
            end else begin
                mb_cnt = mb_cnt + 64'd1;
            end
            mb_state = nxt;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (wrap_b !== wrap) begin
            n_bad++; $display("FAIL b_wrap: got %b expected %b", wrap_b, wrap);
        end
        n_cmp++;
        if (len_b !== mb_len[3:0]) begin
            n_bad++; $display("FAIL b_len: got %0d expected %0d", len_b, mb_len[3:0]);
        end
        if (!sl) begin
            exp = qb.pop_front();
            n_cmp++;
            if (out_data_b !== exp[3:0]) begin
                n_bad++; $display("FAIL b_data: got %h expected %h", out_data_b, exp[3:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({out_data_a, out_valid_a, wrap_a, len_a, err_a} !== 67'h0) begin
            n_bad++; $display("FAIL reset_a: got data=%h v=%b w=%b len=%h e=%b expected all 0",
                              out_data_a, out_valid_a, wrap_a, len_a, err_a);
        end
        n_cmp++;
        if ({out_valid_b, out_valid_c, len_b, len_c} !== 16'h0) begin
            n_bad++; $display("FAIL reset_bc: got vb=%b vc=%b lb=%h lc=%h expected 0",
                              out_valid_b, out_valid_c, len_b, len_c);
        end
        reset_model_a();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_default_seq();
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (out_data_a !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL seq_word0: got %h expected FFFFFFFF", out_data_a);
        end
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (out_data_a !== 32'hFFBF_FFF9) begin
            n_bad++; $display("FAIL seq_word1: got %h expected FFBFFFF9", out_data_a);
        end
        for (int i = 0; i < 8; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        // consume with en low: valid drops, word is not replaced
        cycle_a(1'b0, 1'b0, 32'h0, 1'b1);
        cycle_a(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_seed_load();
        cycle_a(1'b1, 1'b1, 32'h0, 1'b1);
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (out_data_a !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL zero_seed_word: got %h expected FFFFFFFF", out_data_a);
        end
        n_cmp++;
        if (len_a !== 32'h0) begin
            n_bad++; $display("FAIL len_hold: got %h expected 0", len_a);
        end
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        cycle_a(1'b1, 1'b1, 32'h1234_5678, 1'b1);
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (out_data_a !== 32'h1234_5678) begin
            n_bad++; $display("FAIL seed_word: got %h expected 12345678", out_data_a);
        end
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid_a, out_data_a} !== 33'h0) begin
            n_bad++; $display("FAIL async_reset: got v=%b data=%h expected 0", out_valid_a, out_data_a);
        end
        reset_model_a();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (out_data_a !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL restart_word: got %h expected FFFFFFFF", out_data_a);
        end
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 1'b0, 32'h0, 1'b1);
        en_a = 1'b0;
    endtask

    task automatic test_w4();
        logic [3:0] tbl [0:4];
        tbl[0] = 4'hF; tbl[1] = 4'hD; tbl[2] = 4'h9; tbl[3] = 4'h1; tbl[4] = 4'h2;
        mb_state = 64'hF; mb_seed = 64'hF; mb_cnt = '0; mb_len = '0;
        qb.delete();
        for (int i = 0; i < 5; i++) begin
            cycle_b(1'b0, 4'h0);
            n_cmp++;
            if (out_data_b !== tbl[i]) begin
                n_bad++; $display("FAIL w4_word%0d: got %h expected %h", i, out_data_b, tbl[i]);
            end
        end
        for (int i = 0; i < 28; i++) cycle_b(1'b0, 4'h0);
        n_cmp++;
        if (len_b !== 4'd15) begin
            n_bad++; $display("FAIL w4_period: got %0d expected 15", len_b);
        end
        // reload mid-period: counter restarts from the new seed
        cycle_b(1'b1, 4'h5);
        for (int i = 0; i < 17; i++) cycle_b(1'b0, 4'h0);
        en_b = 1'b0;
    endtask

    task automatic test_w10();
        logic [63:0] st, seed, nxt, exp;
        int          wraps, wrap_at;
        logic        wrap;
        st = 64'h3FF; seed = 64'h3FF; wraps = 0; wrap_at = 0;
        qc.delete();
        en_c = 1'b1; rdy_c = 1'b1;
        for (int k = 1; k <= 1030; k++) begin
            qc.push_back(st);
            nxt  = lfsr_step(st, 64'h008, 10);
            wrap = (nxt == seed);
            st   = nxt;
            @(posedge clk); #1;
            exp = qc.pop_front();
            n_cmp++;
            if (out_data_c !== exp[9:0]) begin
                n_bad++; $display("FAIL w10_data@%0d: got %h expected %h", k, out_data_c, exp[9:0]);
            end
            n_cmp++;
            if (wrap_c !== wrap) begin
                n_bad++; $display("FAIL w10_wrap@%0d: got %b expected %b", k, wrap_c, wrap);
            end
            if (wrap_c === 1'b1) begin
                wraps++;
                wrap_at = k;
            end
        end
        en_c = 1'b0;
        n_cmp++;
        if (len_c !== 10'd1023) begin
            n_bad++; $display("FAIL w10_period: got %0d expected 1023", len_c);
        end
        n_cmp++;
        if (wraps != 1 || wrap_at != 1023) begin
            n_bad++; $display("FAIL w10_wrap_count: got %0d wraps at %0d expected 1 at 1023", wraps, wrap_at);
        end
    endtask

    initial begin
        test_reset();
        test_default_seq();
        test_backpressure();
        test_seed_load();
        test_async_reset();
        test_w4();
        test_w10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
